md_sequencer: RTL
=================

# md_sequencer

Multi-cycle sequencer and HI/LO register owner for the multiply/divide resource used by mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It sits beside the EX stage and is driven by the EX-stage MD control fields (MDFunc, MDSign, MDHIWB, MDLOWB) and operands. It runs a fixed-latency countdown per operation, commits results to HI/LO, and raises a pipeline stall whenever an MD-class instruction in EX needs the unit while it is busy.

## Interface
- MUL_CYCLES, 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1).

- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- ex_valid  input  1  EX instruction is valid (not flushed/bubble).
- MDFunc  input  3  0 none, 1 mthi, 2 mtlo, 3 mult/multu, 4 div/divu; 5–7 treated as none.
- MDSign  input  1  1 = signed (mult/div), 0 = unsigned.
- MDHIWB  input  1  EX instruction is mfhi.
- MDLOWB  input  1  EX instruction is mflo.
- A  input  32  rs operand (multiplicand / dividend / mthi-mtlo source).
- B  input  32  rt operand (multiplier / divisor).
- busy  output  1  unit is in MUL or DIV state.
- md_stall  output  1  hold IF/ID/EX, bubble into MEM.
- md_rdata  output  32  HI when MDHIWB, LO when MDLOWB, else 0.
- HI  output  32  HI register.
- LO  output  32  LO register.
- done  output  1  one-cycle pulse in the cycle HI/LO commit from mult/div.

## Operation
- md_req = ex_valid & (MDFunc in 1..4 | MDHIWB | MDLOWB).
- md_stall = md_req & busy. Combinational.
- States: IDLE, MUL, DIV; counter cnt of $clog2(max(MUL_CYCLES,DIV_CYCLES)+1) bits.
- IDLE, md_req, MDFunc=3: latch the 64-bit product of A*B (signed or unsigned by MDSign) into a result register; cnt←MUL_CYCLES-1; → MUL.
- IDLE, md_req, MDFunc=4: latch quotient/remainder; cnt←DIV_CYCLES-1; → DIV.
- IDLE, md_req, MDFunc=1/2: HI←A or LO←A at this edge; stay IDLE; no busy.
- MUL/DIV: cnt decrements each cycle; when cnt==0: HI←res[63:32], LO←res[31:0], done=1, → IDLE.
- The stalled instruction is accepted in the first IDLE cycle.
- Signed div: quotient truncates toward zero; remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0), both signedness modes: LO=0xFFFFFFFF, HI=A.
- mfhi/mflo while IDLE: md_rdata reads the current HI/LO combinationally; no stall.
- ex_valid=0: no start, no write, no stall, regardless of the other inputs.

## Timing
- Reset: state IDLE, cnt=0, HI=0, LO=0, result=0, busy=0, done=0, md_stall=0. Reset mid-operation aborts with no commit.
- mult issued in EX at cycle t:
  - busy=1 in cycles t+1 … t+MUL_CYCLES.
  - done and commit in cycle t+MUL_CYCLES.
  - HI/LO readable from t+MUL_CYCLES+1.
- div: same as mult, with DIV_CYCLES.
- Any md_req in cycles t+1 … t+MUL_CYCLES stalls; an immediately following mflo stalls exactly MUL_CYCLES cycles.
- mthi/mtlo: HI/LO valid the cycle after issue.
- Back-to-back MD ops: the second starts in the cycle after done; there is no idle gap beyond that.

## Configuration
- MD_EARLY_RELEASE_EN defined:
  - busy and md_stall are deasserted in the commit cycle (cnt==0).
  - md_rdata forwards res[63:32]/res[31:0] in that cycle.
  - A new mult/div or mthi/mtlo may be accepted in that cycle. A new mthi/mtlo writes after the commit, so it wins.
  - Stall is one cycle shorter.
- MD_EARLY_RELEASE_EN undefined: behaviour exactly as in Timing.

## Test plan
- Reset → HI=LO=0, busy=0, md_stall=0.
- Reset asserted at cycle 4 of a div → next cycle busy=0, HI=LO=0, no done pulse.
- Signed mult A=0xFFFFFFFD (−3), B=7, mflo following → 5 stall cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; md_rdata=0xFFFFFFEB on release.
- divu A=100, B=7 → after 10 busy cycles LO=14, HI=2; done pulses once.
- div A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div A=5, B=0 → HI=5, LO=0xFFFFFFFF.
- mthi A=0x1234 issued during a mult, and ex_valid=0 with MDFunc=3 while IDLE:
  - mthi stalls until the mult commits, then HI=0x1234.
  - The ex_valid=0 case gives no busy and no stall.

Source files
------------

// File: rtl/md_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer bus: MD control fields and operands in,
// HI/LO, read data and pipeline-stall status out.
interface md_sequencer_if;
  logic        ex_valid;
  logic [2:0]  MDFunc;
  logic        MDSign;
  logic        MDHIWB;
  logic        MDLOWB;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        md_stall;
  logic [31:0] md_rdata;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        done;

  modport master (
    output ex_valid, MDFunc, MDSign, MDHIWB, MDLOWB, A, B,
    input  busy, md_stall, md_rdata, HI, LO, done
  );

  modport slave (
    input  ex_valid, MDFunc, MDSign, MDHIWB, MDLOWB, A, B,
    output busy, md_stall, md_rdata, HI, LO, done
  );
endinterface

// File: rtl/md_sequencer.sv
// Fixed-latency mult/div sequencer owning HI/LO; stalls EX while busy.
// Optional MD_EARLY_RELEASE_EN frees the unit (and forwards the result) in the commit cycle.
module md_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  bus
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        res_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  logic               md_req;
  logic               busy;
  logic               commit;
  logic [31:0]        hi_view;
  logic [31:0]        lo_view;

  // Low 64 bits of the product; operands extended by signedness so one multiplier serves both.
  function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Magnitude division keeps 0x80000000 / -1 wrapping to 0x80000000.
  function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31])           r = -r;
    return {r, q};
  endfunction

  assign md_req = bus.ex_valid &
                  (((bus.MDFunc >= 3'd1) && (bus.MDFunc <= 3'd4)) | bus.MDHIWB | bus.MDLOWB);
  assign commit = (state_q != IDLE) && (cnt_q == '0);

`ifdef MD_EARLY_RELEASE_EN
  assign busy    = (state_q != IDLE) && (cnt_q != '0);
  assign hi_view = commit ? res_q[63:32] : hi_q;
  assign lo_view = commit ? res_q[31:0]  : lo_q;
`else
  assign busy    = (state_q != IDLE);
  assign hi_view = hi_q;
  assign lo_view = lo_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (state_q != IDLE) begin
        if (cnt_q == '0) begin
          hi_q    <= res_q[63:32];
          lo_q    <= res_q[31:0];
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
      // New request; placed after the commit so an mthi/mtlo in the commit cycle wins.
      if (md_req && !busy) begin
        case (bus.MDFunc)
          3'd1: hi_q <= bus.A;
          3'd2: lo_q <= bus.A;
          3'd3: begin
            res_q   <= mul_fn(bus.A, bus.B, bus.MDSign);
            cnt_q   <= CNT_W'(MUL_CYCLES - 1);
            state_q <= MUL;
          end
          3'd4: begin
            res_q   <= div_fn(bus.A, bus.B, bus.MDSign);
            cnt_q   <= CNT_W'(DIV_CYCLES - 1);
            state_q <= DIV;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.md_stall = md_req & busy;
  assign bus.done     = commit;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.md_rdata = bus.MDHIWB ? hi_view : (bus.MDLOWB ? lo_view : 32'd0);

endmodule
